// File: rtl/datapath_pkg.sv
// Shared datapath definitions used by the registers, bus mux, ALU and control unit.
//   WORD_WIDTH : native datapath word width
//   word_t     : one datapath word
package datapath_pkg;

  localparam int unsigned WORD_WIDTH = 16;

  typedef logic [WORD_WIDTH-1:0] word_t;

endpackage : datapath_pkg

// File: rtl/registrador_bus.sv
// General-purpose datapath register (R0..R7, A, G style).
// Captures the shared bus on a rising clock edge when write-enabled. On
// synchronous reset it loads a caller-supplied preload value, so the control
// unit can seed or restore register contents.
// Ports:
//   clock          : rising-edge clock
//   valor_anterior : preload value loaded while reset is high
//   buswire        : shared data bus, captured when wren is high
//   wren           : write enable, active-high
//   data_out       : stored value, straight from the flops
//   reset          : synchronous, active-high; beats wren
// Port order keeps reset last so older five-connection positional instances
// still map clock/valor_anterior/buswire/wren/data_out correctly.
module registrador_bus
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_WIDTH
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] valor_anterior,
  input  logic [WIDTH-1:0] buswire,
  input  logic             wren,
  output logic [WIDTH-1:0] data_out,
  input  logic             reset
);

  // Storage: reset preload > bus write > hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= valor_anterior;
    end else if (wren) begin
      data_out <= buswire;
    end
  end

endmodule : registrador_bus

// File: tb/tb_registrador_bus.sv
// Directed self-checking bench for registrador_bus.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_registrador_bus;

  localparam int unsigned W = 16;

  logic         clock;
  logic         reset;
  logic [W-1:0] valor_anterior;
  logic [W-1:0] buswire;
  logic         wren;
  logic [W-1:0] data_out;

  int compared;
  int mismatched;

  registrador_bus #(.WIDTH(W)) dut (
    .clock          (clock),
    .valor_anterior (valor_anterior),
    .buswire        (buswire),
    .wren           (wren),
    .data_out       (data_out),
    .reset          (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] expected);
    compared++;
    assert (data_out === expected) else begin
      mismatched++;
      $error("FAIL %s: data_out=%h expected=%h", tag, data_out, expected);
    end
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    reset          = 1'b0;
    wren           = 1'b0;
    valor_anterior = 16'h0000;
    buswire        = 16'h0000;
    #1;

    // Reset beats a simultaneous write.
    reset = 1'b1; wren = 1'b1; valor_anterior = 16'h1234; buswire = 16'h0002;
    tick();
    check("reset_preload", 16'h1234);

    // Basic writes.
    reset = 1'b0; wren = 1'b1; buswire = 16'h0002;
    tick();
    check("write_0002", 16'h0002);
    buswire = 16'h0007;
    tick();
    check("write_0007", 16'h0007);

    // Hold for three edges with wren low.
    wren = 1'b0; buswire = 16'hABCD;
    tick();
    check("hold_1", 16'h0007);
    tick();
    check("hold_2", 16'h0007);
    tick();
    check("hold_3", 16'h0007);

    // Preload input ignored when reset is low.
    valor_anterior = 16'h5A5A;
    tick();
    check("hold_preload_ignored", 16'h0007);

    // No combinational path from buswire.
    wren = 1'b1; buswire = 16'h0002;
    tick();
    check("write_before_glitch", 16'h0002);
    @(negedge clock);
    buswire = 16'h0005;
    #1;
    check("midcycle_no_comb", 16'h0002);
    tick();
    check("write_after_glitch", 16'h0005);

    // Full-width extremes.
    buswire = 16'hFFFF;
    tick();
    check("write_ffff", 16'hFFFF);
    buswire = 16'h0000;
    tick();
    check("write_0000", 16'h0000);

    // Reset mid-operation.
    buswire = 16'h00FF;
    tick();
    check("write_00ff", 16'h00FF);
    reset = 1'b1; wren = 1'b0; valor_anterior = 16'h8001;
    tick();
    check("reset_mid", 16'h8001);
    reset = 1'b0; wren = 1'b1; buswire = 16'h0003;
    tick();
    check("write_after_reset", 16'h0003);

    // Reset high for two edges follows a changing preload.
    reset = 1'b1; valor_anterior = 16'h4321;
    tick();
    check("reset_hold_a", 16'h4321);
    valor_anterior = 16'hC0DE;
    tick();
    check("reset_hold_b", 16'hC0DE);

    // Back to hold after reset.
    reset = 1'b0; wren = 1'b0; valor_anterior = 16'h1111; buswire = 16'h2222;
    tick();
    check("hold_after_reset", 16'hC0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_registrador_bus
